// File: rtl/matraptor_core.sv
// MatRaptor row-merge core: triples are routed by row to PEs that sort them into column-ascending queues and merge them.
// Build option MATRAPTOR_ZERO_SKIP_EN: merged sums of zero are dropped and out_last moves to the last non-zero output.

module matraptor_pe #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 16,
  parameter int NQ      = 8,
  parameter int Q_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_last_hs,
  input  logic [DATA_W-1:0] in_val,
  input  logic [IDX_W-1:0]  in_row,
  input  logic [IDX_W-1:0]  in_col,
  output logic              ready,
  output logic              row_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_val,
  output logic [IDX_W-1:0]  out_col,
  output logic              out_last
);
  // state          | meaning
  // S_RESET        | one idle cycle after reset, no input accepted
  // S_FILL         | accept triples of the current row into the queues
  // S_ROW_FLUSH    | row closed, input stalled
  // S_MERGE_START  | merge setup cycle
  // S_MERGE_FIND   | pick minimum head column and its sum
  // S_MERGE_OUTPUT | present merged entry until out_ready
  // S_MERGE_NEXT_Q | pulse row_done, clear queues
  typedef enum logic [2:0] {
    S_RESET        = 3'd0,
    S_FILL         = 3'd1,
    S_ROW_FLUSH    = 3'd2,
    S_MERGE_START  = 3'd3,
    S_MERGE_FIND   = 3'd4,
    S_MERGE_OUTPUT = 3'd5,
    S_MERGE_NEXT_Q = 3'd6
  } state_t;

  // Q_DEPTH must be a power of two >= 2; pointers carry one extra bit for the full case
  localparam int PW = $clog2(Q_DEPTH);
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam logic [PW:0] ONE      = (PW+1)'(1);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(Q_DEPTH);

  state_t state, n_state;

  logic [IDX_W-1:0]  q_col [NQ][Q_DEPTH];
  logic [DATA_W-1:0] q_val [NQ][Q_DEPTH];
  logic [PW:0]       wr_ptr [NQ];
  logic [PW:0]       rd_ptr [NQ];
  logic [PW:0]       tail_ptr [NQ];
  logic [IDX_W-1:0]  head_col [NQ];
  logic [IDX_W-1:0]  tail_col [NQ];
  logic [DATA_W-1:0] head_val [NQ];
  logic [DATA_W-1:0] tail_val [NQ];
  logic [NQ-1:0]     q_used, q_empty, q_full, q_last;

  logic              row_active;
  logic [IDX_W-1:0]  merge_row;
  logic              accept, ins_found, ins_open, wr_en, wr_add;
  logic [QW-1:0]     tgt;
  logic              any_ne;
  logic [IDX_W-1:0]  min_col;
  logic [DATA_W-1:0] grp_sum;
  logic [NQ-1:0]     grp;
  logic [NQ-1:0]     pop, ld_mask, pop_mask_r;
  logic              q_clear, ld_out, ld_last;
  logic [IDX_W-1:0]  ld_col;
  logic [DATA_W-1:0] ld_val;
`ifdef MATRAPTOR_ZERO_SKIP_EN
  logic              ld_pend, pend_clr, pend_v;
  logic [IDX_W-1:0]  pend_col;
  logic [DATA_W-1:0] pend_val;
`else
  logic              grp_last;
`endif

  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      tail_ptr[q] = wr_ptr[q] - ONE;
      q_used[q]   = (wr_ptr[q] != '0);
      q_empty[q]  = (rd_ptr[q] == wr_ptr[q]);
      q_full[q]   = (wr_ptr[q] == FULL_CNT);
      q_last[q]   = ((rd_ptr[q] + ONE) == wr_ptr[q]);
      head_col[q] = q_col[q][rd_ptr[q][PW-1:0]];
      head_val[q] = q_val[q][rd_ptr[q][PW-1:0]];
      tail_col[q] = q_col[q][tail_ptr[q][PW-1:0]];
      tail_val[q] = q_val[q][tail_ptr[q][PW-1:0]];
    end
  end

  // queues are opened in index order, so the first unused one is also the next unused one
  always_comb begin
    ready     = (state == S_FILL) && (!row_active || (in_row == merge_row));
    accept    = in_valid && ready;
    ins_found = 1'b0;
    ins_open  = 1'b0;
    tgt       = '0;
    for (int q = 0; q < NQ; q++) begin
      if (!ins_found && q_used[q] && (tail_col[q] <= in_col)) begin
        ins_found = 1'b1;
        tgt       = QW'(q);
      end
    end
    for (int q = 0; q < NQ; q++) begin
      if (!ins_found && !ins_open && !q_used[q]) begin
        ins_open = 1'b1;
        tgt      = QW'(q);
      end
    end
    wr_add = ins_found && (tail_col[tgt] == in_col);
    wr_en  = accept && (ins_found || ins_open) && !q_full[tgt];
  end

  always_comb begin
    any_ne  = 1'b0;
    min_col = '0;
    for (int q = 0; q < NQ; q++) begin
      if (!q_empty[q] && (!any_ne || (head_col[q] < min_col))) begin
        min_col = head_col[q];
        any_ne  = 1'b1;
      end
    end
    grp     = '0;
    grp_sum = '0;
`ifndef MATRAPTOR_ZERO_SKIP_EN
    grp_last = 1'b1;
`endif
    for (int q = 0; q < NQ; q++) begin
      if (!q_empty[q]) begin
        if (head_col[q] == min_col) begin
          grp[q]  = 1'b1;
          grp_sum = grp_sum + head_val[q];
`ifndef MATRAPTOR_ZERO_SKIP_EN
          grp_last = grp_last & q_last[q];
        end else begin
          grp_last = 1'b0;
`endif
        end
      end
    end
  end

  always_comb begin
    n_state = state;
    pop     = '0;
    ld_mask = '0;
    q_clear = 1'b0;
    ld_out  = 1'b0;
    ld_last = 1'b0;
    ld_col  = min_col;
    ld_val  = grp_sum;
`ifdef MATRAPTOR_ZERO_SKIP_EN
    ld_pend  = 1'b0;
    pend_clr = 1'b0;
`endif
    case (state)
      S_RESET: n_state = S_FILL;
      S_FILL: begin
        if ((in_last_hs && (row_active || accept)) ||
            (in_valid && row_active && (in_row != merge_row)))
          n_state = S_ROW_FLUSH;
      end
      S_ROW_FLUSH:   n_state = S_MERGE_START;
      S_MERGE_START: n_state = S_MERGE_FIND;
      S_MERGE_FIND: begin
`ifdef MATRAPTOR_ZERO_SKIP_EN
        // one non-zero entry is held back so out_last can be placed once the row end is known
        if (!any_ne) begin
          if (pend_v) begin
            ld_out   = 1'b1;
            ld_col   = pend_col;
            ld_val   = pend_val;
            ld_last  = 1'b1;
            pend_clr = 1'b1;
            n_state  = S_MERGE_OUTPUT;
          end else begin
            n_state = S_MERGE_NEXT_Q;
          end
        end else begin
          pop = grp;
          if (grp_sum != '0) begin
            ld_pend = 1'b1;
            if (pend_v) begin
              ld_out  = 1'b1;
              ld_col  = pend_col;
              ld_val  = pend_val;
              n_state = S_MERGE_OUTPUT;
            end
          end
        end
`else
        if (!any_ne) begin
          n_state = S_MERGE_NEXT_Q;
        end else begin
          ld_out  = 1'b1;
          ld_last = grp_last;
          ld_mask = grp;
          n_state = S_MERGE_OUTPUT;
        end
`endif
      end
      S_MERGE_OUTPUT: begin
        if (out_ready) begin
          pop     = pop_mask_r;
          n_state = S_MERGE_FIND;
        end
      end
      S_MERGE_NEXT_Q: begin
        q_clear = 1'b1;
        n_state = S_FILL;
      end
      default: n_state = S_RESET;
    endcase
  end

  assign out_valid = (state == S_MERGE_OUTPUT);
  assign row_done  = (state == S_MERGE_NEXT_Q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RESET;
    else        state <= n_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_active <= 1'b0;
      merge_row  <= '0;
    end else if (q_clear) begin
      row_active <= 1'b0;
    end else if (accept && !row_active) begin
      row_active <= 1'b1;
      merge_row  <= in_row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < NQ; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
      end
    end else if (q_clear) begin
      for (int q = 0; q < NQ; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
      end
    end else begin
      if (wr_en && !wr_add) wr_ptr[tgt] <= wr_ptr[tgt] + ONE;
      for (int q = 0; q < NQ; q++)
        if (pop[q]) rd_ptr[q] <= rd_ptr[q] + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_add) begin
        q_val[tgt][tail_ptr[tgt][PW-1:0]] <= tail_val[tgt] + in_val;
      end else begin
        q_col[tgt][wr_ptr[tgt][PW-1:0]] <= in_col;
        q_val[tgt][wr_ptr[tgt][PW-1:0]] <= in_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_col    <= '0;
      out_val    <= '0;
      out_last   <= 1'b0;
      pop_mask_r <= '0;
    end else if (ld_out) begin
      out_col    <= ld_col;
      out_val    <= ld_val;
      out_last   <= ld_last;
      pop_mask_r <= ld_mask;
    end
  end

`ifdef MATRAPTOR_ZERO_SKIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_v   <= 1'b0;
      pend_col <= '0;
      pend_val <= '0;
    end else if (ld_pend) begin
      pend_v   <= 1'b1;
      pend_col <= min_col;
      pend_val <= grp_sum;
    end else if (pend_clr) begin
      pend_v <= 1'b0;
    end
  end
`endif
endmodule

module matraptor_core #(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 16,
  parameter int NQ      = 8,
  parameter int Q_DEPTH = 256,
  parameter int NUM_PES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_val,
  input  logic [IDX_W-1:0]   in_row,
  input  logic [IDX_W-1:0]   in_col,
  input  logic               in_last,
  output logic [NUM_PES-1:0] pe_row_done,
  output logic [NUM_PES-1:0] out_valid,
  input  logic [NUM_PES-1:0] out_ready,
  output logic [DATA_W-1:0]  out_val [NUM_PES],
  output logic [IDX_W-1:0]   out_col [NUM_PES],
  output logic [NUM_PES-1:0] out_last
);
  logic [IDX_W-1:0]   sel;
  logic [NUM_PES-1:0] pe_ready;
  logic               last_hs;

  assign sel = in_row % IDX_W'(NUM_PES);

  always_comb begin
    in_ready = 1'b0;
    for (int p = 0; p < NUM_PES; p++)
      if (sel == IDX_W'(p)) in_ready = pe_ready[p];
  end

  // in_last closes the row in every PE, not only the one receiving it
  assign last_hs = in_valid && in_ready && in_last;

  for (genvar p = 0; p < NUM_PES; p++) begin : PES
    matraptor_pe #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .NQ     (NQ),
      .Q_DEPTH(Q_DEPTH)
    ) U_PE (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid && (sel == IDX_W'(p))),
      .in_last_hs(last_hs),
      .in_val    (in_val),
      .in_row    (in_row),
      .in_col    (in_col),
      .ready     (pe_ready[p]),
      .row_done  (pe_row_done[p]),
      .out_valid (out_valid[p]),
      .out_ready (out_ready[p]),
      .out_val   (out_val[p]),
      .out_col   (out_col[p]),
      .out_last  (out_last[p])
    );
  end
endmodule

// File: tb/tb_matraptor_core.sv
// Directed table-driven bench for matraptor_core with one PE: row merges, stall, hold and reset abort.
module tb_matraptor_core;
  localparam int DW = 32;
  localparam int IW = 16;
  localparam int NP = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_val = '0;
  logic [IW-1:0] in_row = '0, in_col = '0;
  logic [NP-1:0] pe_row_done, out_valid, out_last;
  logic [NP-1:0] out_ready = '1;
  logic [DW-1:0] out_val [NP];
  logic [IW-1:0] out_col [NP];

  always #5 clk = ~clk;

  matraptor_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_val(in_val), .in_row(in_row), .in_col(in_col), .in_last(in_last),
    .pe_row_done(pe_row_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_val(out_val), .out_col(out_col), .out_last(out_last)
  );

  typedef struct { int t; logic [IW-1:0] row; logic [IW-1:0] col; logic [DW-1:0] val; logic last; } vec_t;
  typedef struct { int t; logic [IW-1:0] col; logic [DW-1:0] val; logic last; } exp_t;

  vec_t vin[$];
  exp_t vexp[$];
  int   ndone [4] = '{1, 2, 1, 1};
  int   exp_row [4] = '{0, 1, 5, 7};

  int checks = 0;
  int errors = 0;

  int            got_n = 0;
  logic [IW-1:0] got_col [512];
  logic [DW-1:0] got_val [512];
  logic          got_last [512];
  int            done_n = 0;
  logic [IW-1:0] done_row = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid[0] && out_ready[0] && got_n < 512) begin
        got_col[got_n]  = out_col[0];
        got_val[got_n]  = out_val[0];
        got_last[got_n] = out_last[0];
        got_n++;
      end
      if (pe_row_done[0]) begin
        done_row = dut.PES[0].U_PE.merge_row;
        done_n++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [IW-1:0] row, input logic [IW-1:0] col,
                      input logic [DW-1:0] val, input logic last, output int done_at_acc);
    int n;
    in_valid = 1'b1; in_row = row; in_col = col; in_val = val; in_last = last;
    n = 0;
    done_at_acc = -1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        done_at_acc = done_n;
        break;
      end
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL send_timeout row %0d col %0d", row, col);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_n < target) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL row_done_timeout got %0d exp %0d", done_n, target);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid[0]) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL out_valid_timeout got 0 exp 1");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int base_got, base_done, acc;
    int nexp;

    vin.push_back('{0, 16'd0, 16'd3, 32'd2, 1'b0});
    vin.push_back('{0, 16'd0, 16'd1, 32'd5, 1'b0});
    vin.push_back('{0, 16'd0, 16'd3, 32'd4, 1'b1});
    vexp.push_back('{0, 16'd1, 32'd5, 1'b0});
    vexp.push_back('{0, 16'd3, 32'd6, 1'b1});

    vin.push_back('{1, 16'd0, 16'd2, 32'd1, 1'b0});
    vin.push_back('{1, 16'd1, 16'd0, 32'd7, 1'b1});
    vexp.push_back('{1, 16'd2, 32'd1, 1'b1});
    vexp.push_back('{1, 16'd0, 32'd7, 1'b1});

    vin.push_back('{2, 16'd5, 16'd4, 32'd3, 1'b0});
    vin.push_back('{2, 16'd5, 16'd1, 32'd1, 1'b0});
    vin.push_back('{2, 16'd5, 16'd4, 32'hFFFF_FFFD, 1'b1});
`ifdef MATRAPTOR_ZERO_SKIP_EN
    vexp.push_back('{2, 16'd1, 32'd1, 1'b1});
`else
    vexp.push_back('{2, 16'd1, 32'd1, 1'b0});
    vexp.push_back('{2, 16'd4, 32'd0, 1'b1});
`endif

    for (int c = 8; c >= 0; c--)
      vin.push_back('{3, 16'd7, IW'(c), DW'(c + 100), (c == 0)});
    for (int c = 1; c <= 8; c++)
      vexp.push_back('{3, IW'(c), DW'(c + 100), (c == 8)});

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_col", out_col[0], 0);
    check("rst_out_val", out_val[0], 0);
    check("rst_out_last", out_last, 0);
    check("rst_row_done", pe_row_done, 0);
    check("rst_state", dut.PES[0].U_PE.state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int t = 0; t < 4; t++) begin
      base_got  = got_n;
      base_done = done_n;
      foreach (vin[i]) begin
        if (vin[i].t == t) begin
          send(vin[i].row, vin[i].col, vin[i].val, vin[i].last, acc);
          if (t == 1 && vin[i].row == 16'd1)
            check("t1_stall_until_row0_done", acc - base_done, 1);
        end
      end
      wait_done(base_done + ndone[t]);
      check($sformatf("t%0d_done_row", t), done_row, exp_row[t]);
      nexp = 0;
      foreach (vexp[i]) if (vexp[i].t == t) nexp++;
      check($sformatf("t%0d_out_count", t), got_n - base_got, nexp);
      nexp = 0;
      foreach (vexp[i]) begin
        if (vexp[i].t == t) begin
          if (base_got + nexp < got_n) begin
            check($sformatf("t%0d_out%0d_col", t, nexp), got_col[base_got + nexp], vexp[i].col);
            check($sformatf("t%0d_out%0d_val", t, nexp), got_val[base_got + nexp], vexp[i].val);
            check($sformatf("t%0d_out%0d_last", t, nexp), got_last[base_got + nexp], vexp[i].last);
          end
          nexp++;
        end
      end
    end

    // out_ready held low: the first merged entry must stay put
    base_got  = got_n;
    base_done = done_n;
    out_ready = '0;
    send(16'd9, 16'd2, 32'd1, 1'b0, acc);
    send(16'd9, 16'd5, 32'd2, 1'b1, acc);
    wait_out_valid();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold%0d_valid", k), out_valid, 1);
      check($sformatf("hold%0d_col", k), out_col[0], 2);
      check($sformatf("hold%0d_val", k), out_val[0], 1);
      check($sformatf("hold%0d_last", k), out_last, 0);
      @(posedge clk); #1;
    end
    out_ready = '1;
    wait_done(base_done + 1);
    check("hold_out_count", got_n - base_got, 2);
    check("hold_out0", {got_col[base_got], got_val[base_got], 7'd0, got_last[base_got]}, {16'd2, 32'd1, 8'd0});
    check("hold_out1", {got_col[base_got+1], got_val[base_got+1], 7'd0, got_last[base_got+1]}, {16'd5, 32'd2, 8'd1});

    // reset in the middle of a merge aborts it and clears every queue
    base_got  = got_n;
    base_done = done_n;
    out_ready = '0;
    send(16'd3, 16'd1, 32'd4, 1'b0, acc);
    send(16'd3, 16'd2, 32'd6, 1'b1, acc);
    wait_out_valid();
    check("pre_abort_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_val", out_val[0], 0);
    check("abort_out_col", out_col[0], 0);
    check("abort_out_last", out_last, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_state", dut.PES[0].U_PE.state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_state_reset", dut.PES[0].U_PE.state, 0);
    @(posedge clk); #1;
    check("post_rst_state_fill", dut.PES[0].U_PE.state, 1);
    out_ready = '1;
    send(16'd4, 16'd3, 32'd9, 1'b1, acc);
    wait_done(base_done + 1);
    check("post_rst_out_count", got_n - base_got, 1);
    check("post_rst_out0", {got_col[base_got], got_val[base_got], 7'd0, got_last[base_got]}, {16'd3, 32'd9, 8'd1});
    check("post_rst_done_row", done_row, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
